// File: rtl/adder_result_accumulator.sv
// Batch accumulator for 5-bit adder results: sums COUNT results over a valid/ready
// handshake and presents the total with a sticky overflow flag.
module adder_result_accumulator #(
   parameter int unsigned IN_W  = 5,
   parameter int unsigned ACC_W = 6,
   parameter int unsigned COUNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_overflow,
   output logic             busy
);

   localparam int unsigned CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam int unsigned SUM_W = ACC_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc, acc_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ovf, ovf_nxt;
   logic [SUM_W-1:0] sum_ext;

   // One extra bit captures the carry out of the ACC_W-bit addition
   assign sum_ext = {1'b0, acc} + SUM_W'(in_data);

   // State and datapath registers; outputs are registered decodes of the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         acc          <= '0;
         cnt          <= '0;
         ovf          <= 1'b0;
         in_ready     <= 1'b0;
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_overflow <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         acc          <= acc_nxt;
         cnt          <= cnt_nxt;
         ovf          <= ovf_nxt;
         in_ready     <= (state_nxt == ACCUM);
         out_valid    <= (state_nxt == DONE);
         out_sum      <= (state_nxt == DONE) ? acc_nxt : '0;
         out_overflow <= (state_nxt == DONE) ? ovf_nxt : 1'b0;
         busy         <= (state_nxt != IDLE);
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      case (state)
         IDLE: begin
            if (start) begin
               acc_nxt   = '0;
               ovf_nxt   = 1'b0;
               cnt_nxt   = '0;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid && in_ready) begin
               acc_nxt = sum_ext[ACC_W-1:0];
               ovf_nxt = ovf | sum_ext[ACC_W];
               if (cnt == CNT_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
